// File: rtl/reservation_station_pkg.sv
// Shared widths, op codes and entry layout for the reservation station slice.
package reservation_station_pkg;

    localparam int ROB_SIZE_LOG = 4;
    localparam int OP_SIZE_LOG  = 5;
    localparam int RS_SIZE_LOG  = 3;

    localparam logic [OP_SIZE_LOG-1:0] OP_ADD = 5'd1;
    localparam logic [OP_SIZE_LOG-1:0] OP_SUB = 5'd2;
    localparam logic [OP_SIZE_LOG-1:0] OP_BEQ = 5'd10;
    localparam logic [OP_SIZE_LOG-1:0] OP_LUI = 5'd20;

    typedef struct packed {
        logic [OP_SIZE_LOG-1:0]  op;
        logic [31:0]             vj;
        logic [31:0]             vk;
        logic [ROB_SIZE_LOG-1:0] qj;
        logic [ROB_SIZE_LOG-1:0] qk;
        logic                    rj;
        logic                    rk;
        logic [31:0]             imm;
        logic [31:0]             pc;
        logic [ROB_SIZE_LOG-1:0] robid;
    } rs_entry_t;

    // Returns {ready, value}; the ALU bus takes precedence when both buses carry the tag.
    function automatic logic [32:0] cdb_capture(
        input logic                    r,
        input logic [ROB_SIZE_LOG-1:0] q,
        input logic [31:0]             v,
        input logic                    a_valid,
        input logic [ROB_SIZE_LOG-1:0] a_robid,
        input logic [31:0]             a_value,
        input logic                    l_valid,
        input logic [ROB_SIZE_LOG-1:0] l_robid,
        input logic [31:0]             l_value
    );
        if (r)                          return {1'b1, v};
        if (a_valid && a_robid == q)    return {1'b1, a_value};
        if (l_valid && l_robid == q)    return {1'b1, l_value};
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/reservation_station_select.sv
// Lowest-index priority encoder: index of the first set request bit plus a found flag.
module rs_select #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         found
);

    always_comb begin
        idx   = '0;
        found = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = W'(i);
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Reservation station for non-memory ops: captures operands or tags, wakes them
// from the ALU/LSB CDBs and dispatches one ready entry per cycle to the ALU.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int RS_SIZE = 1 << RS_SIZE_LOG
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    clear,
    input  logic                    issue_enable,
    input  logic [OP_SIZE_LOG-1:0]  issue_op,
    input  logic [31:0]             issue_vj,
    input  logic [31:0]             issue_vk,
    input  logic [ROB_SIZE_LOG-1:0] issue_qj,
    input  logic [ROB_SIZE_LOG-1:0] issue_qk,
    input  logic                    issue_rj,
    input  logic                    issue_rk,
    input  logic [31:0]             issue_imm,
    input  logic [31:0]             issue_pc,
    input  logic [ROB_SIZE_LOG-1:0] issue_robid,
    input  logic                    alu_cdb_valid,
    input  logic [ROB_SIZE_LOG-1:0] alu_cdb_robid,
    input  logic [31:0]             alu_cdb_value,
    input  logic                    lsb_cdb_valid,
    input  logic [ROB_SIZE_LOG-1:0] lsb_cdb_robid,
    input  logic [31:0]             lsb_cdb_value,
    output logic                    rs_full,
    output logic                    alu_enable,
    output logic [OP_SIZE_LOG-1:0]  alu_op,
    output logic [31:0]             alu_vj,
    output logic [31:0]             alu_vk,
    output logic [31:0]             alu_imm,
    output logic [31:0]             alu_pc,
    output logic [ROB_SIZE_LOG-1:0] alu_robid
);

    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] busy;
    rs_entry_t          ent [RS_SIZE];

    logic [RS_SIZE-1:0] ready_vec;
    logic [IDX_W-1:0]   free_idx, ready_idx;
    logic               free_found, ready_found;
    logic [IDX_W:0]     free_cnt;
    rs_entry_t          new_ent;

    always_comb begin
        ready_vec = '0;
        free_cnt  = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            ready_vec[i] = busy[i] & ent[i].rj & ent[i].rk;
            free_cnt     = free_cnt + {{IDX_W{1'b0}}, ~busy[i]};
        end
    end

    // One spare slot covers the instruction already in flight in the front end.
    assign rs_full = (free_cnt <= (IDX_W+1)'(1));

    rs_select #(.N(RS_SIZE)) u_free_sel (
        .req   (~busy),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_select #(.N(RS_SIZE)) u_ready_sel (
        .req   (ready_vec),
        .idx   (ready_idx),
        .found (ready_found)
    );

    always_comb begin
        new_ent       = '0;
        new_ent.op    = issue_op;
        new_ent.qj    = issue_qj;
        new_ent.qk    = issue_qk;
        new_ent.imm   = issue_imm;
        new_ent.pc    = issue_pc;
        new_ent.robid = issue_robid;
        {new_ent.rj, new_ent.vj} = cdb_capture(issue_rj, issue_qj, issue_vj,
            alu_cdb_valid, alu_cdb_robid, alu_cdb_value,
            lsb_cdb_valid, lsb_cdb_robid, lsb_cdb_value);
        {new_ent.rk, new_ent.vk} = cdb_capture(issue_rk, issue_qk, issue_vk,
            alu_cdb_valid, alu_cdb_robid, alu_cdb_value,
            lsb_cdb_valid, lsb_cdb_robid, lsb_cdb_value);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            alu_enable <= 1'b0;
            alu_op     <= '0;
            alu_vj     <= '0;
            alu_vk     <= '0;
            alu_imm    <= '0;
            alu_pc     <= '0;
            alu_robid  <= '0;
        end else if (rdy) begin
            if (clear) begin
                busy       <= '0;
                alu_enable <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy[i]) begin
                        {ent[i].rj, ent[i].vj} <= cdb_capture(ent[i].rj, ent[i].qj, ent[i].vj,
                            alu_cdb_valid, alu_cdb_robid, alu_cdb_value,
                            lsb_cdb_valid, lsb_cdb_robid, lsb_cdb_value);
                        {ent[i].rk, ent[i].vk} <= cdb_capture(ent[i].rk, ent[i].qk, ent[i].vk,
                            alu_cdb_valid, alu_cdb_robid, alu_cdb_value,
                            lsb_cdb_valid, lsb_cdb_robid, lsb_cdb_value);
                    end
                end
                alu_enable <= ready_found;
                if (ready_found) begin
                    alu_op          <= ent[ready_idx].op;
                    alu_vj          <= ent[ready_idx].vj;
                    alu_vk          <= ent[ready_idx].vk;
                    alu_imm         <= ent[ready_idx].imm;
                    alu_pc          <= ent[ready_idx].pc;
                    alu_robid       <= ent[ready_idx].robid;
                    busy[ready_idx] <= 1'b0;
                end
                // free_idx comes from registered busy, so it never aliases the slot dispatched now.
                if (issue_enable && free_found) begin
                    busy[free_idx] <= 1'b1;
                    ent[free_idx]  <= new_ent;
                end
            end
        end
    end

endmodule

// File: doc/reservation_station.md
# reservation_station

Holds issued non-memory instructions (ALU, branch, jump, LUI/AUIPC) between the issue stage and the ALU. Captures operand values or ROB tags, wakes operands from two common-data-bus (CDB) broadcasts, and dispatches at most one ready instruction per cycle to the ALU. Fed by the issue stage's `rs_send_enable` and operand outputs. Flushed by the ROB on branch misprediction.

## Interface
- `RS_SIZE`, 8: number of entries; power of two, ≥ 4.
- `ROB_SIZE_LOG`, from `utils.v`: ROB tag width.
- `OP_SIZE_LOG`, from `utils.v`: op_type width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rdy`  in  1  global enable; low means no state change and outputs hold.
- `clear`  in  1  ROB flush (misprediction).
- `issue_enable`  in  1  from issue `rs_send_enable`.
- `issue_op`  in  OP_SIZE_LOG  decoded op_type.
- `issue_vj`, `issue_vk`  in  32  operand values.
- `issue_qj`, `issue_qk`  in  ROB_SIZE_LOG  producer tags.
- `issue_rj`, `issue_rk`  in  1  operand valid.
- `issue_imm`, `issue_pc`  in  32  immediate and instruction PC.
- `issue_robid`  in  ROB_SIZE_LOG  destination ROB entry.
- `alu_cdb_valid`, `alu_cdb_robid`, `alu_cdb_value`  in  1/ROB_SIZE_LOG/32  ALU broadcast.
- `lsb_cdb_valid`, `lsb_cdb_robid`, `lsb_cdb_value`  in  1/ROB_SIZE_LOG/32  load-buffer broadcast.
- `rs_full`  out  1  back-pressure to fetch/issue.
- `alu_enable`  out  1  dispatch valid, registered.
- `alu_op`, `alu_vj`, `alu_vk`, `alu_imm`, `alu_pc`, `alu_robid`  out  OP_SIZE_LOG/32/32/32/32/ROB_SIZE_LOG  dispatched payload, registered.

## Operation
- Entry fields: `busy`, `op`, `vj`, `vk`, `qj`, `qk`, `rj`, `rk`, `imm`, `pc`, `robid`.
- Update priority: `rst` > `!rdy` (hold) > `clear` > normal operation.
- On `rst` or `clear`: all `busy` = 0; `alu_enable` = 0 at that edge.
- Reset value of all `alu_*` outputs is 0; `rs_full` = 0 after reset.
- Issue:
  - When `issue_enable` is high, write the lowest-index entry whose registered `busy` = 0.
  - A slot freed by dispatch at the same edge is not reused at that edge.
- Issue-time forwarding:
  - If an incoming operand has r = 0 and its q matches a valid CDB this cycle, the entry stores the CDB value with r = 1.
  - The ALU CDB wins if both buses match.
- Wakeup: every busy entry with rj = 0 and qj == a valid CDB robid sets vj to the CDB value and rj to 1. The same rule applies to k.
- Select: the lowest-index entry with registered busy & rj & rk. The sub-module `rs_select` provides both the free-slot and ready-slot priority encoders.
- Dispatch:
  - Selected entry's fields go to the `alu_*` registers.
  - `alu_enable` = 1, and the entry's `busy` = 0 at the same edge.
  - With no ready entry, `alu_enable` = 0 and `alu_*` payload holds its last value.
- `rs_full`: combinational from registered `busy`; high when the free-entry count is ≤ 1. This covers one instruction in flight in the front end.
- `issue_enable` with zero free entries is a protocol violation: the instruction is dropped, and the bench asserts it never occurs.

## Timing
- Issue at edge E0 with both operands ready: entry written at E0; `alu_enable` high in the cycle after E1. Minimum latency is one full cycle of residency.
- CDB wakeup at edge Ew: the entry becomes eligible for select in the cycle after Ew, and dispatches at Ew+1 at the earliest.
- Issue-time forwarding gives the same latency as issuing with ready operands.
- `alu_enable` is a one-cycle pulse per dispatched instruction. Back-to-back dispatch in consecutive cycles is allowed.
- `clear` coincident with `issue_enable`: the issue is discarded and the RS is empty after the edge.
- `clear` coincident with a ready entry: no dispatch; `alu_enable` = 0.
- `rst` asserted mid-operation: identical to the reset state after one edge.
- `rdy` low: busy, entries and all outputs are frozen. CDB inputs during that cycle are ignored; producers hold them under `rdy`.
- Wrap/overflow: none. Tags are compared by equality only.

## Structure
- `OP_*` codes, `ROB_SIZE_LOG` and `OP_SIZE_LOG` come from `utils.v`. Add `RS_SIZE_LOG` there as well.
- The one sub-module is `rs_select`, a parameterised lowest-index priority encoder. It is instantiated twice (free slot, ready slot) and outputs an index plus a found flag.

## Test plan
- Issue ADD with `vj`=5, `vk`=7, `rj`=`rk`=1, `robid`=3:
  - → `alu_enable` pulses exactly once, 2 edges after issue, with `alu_vj`=5, `alu_vk`=7, `alu_robid`=3.
- Issue with `qj`=2, `rj`=0; two cycles later `alu_cdb_valid`, robid 2, value 0xDEADBEEF:
  - → dispatch one cycle after the broadcast, with `alu_vj`=0xDEADBEEF.
- Issue with `qk`=6, `rk`=0 in the same cycle as `lsb_cdb_valid`, robid 6, value 42:
  - → stored ready; dispatches with `alu_vk`=42 at the 2-edge latency.
- Fill 7 blocked entries:
  - → `rs_full`=1 at 7 busy, 0 at 6 busy.
  - Wake entries 4 and 1 at once → entry 1 dispatches first, entry 4 on the next cycle.
- Six busy entries plus `clear` together with `issue_enable`:
  - → next cycle all free, `rs_full`=0, and no `alu_enable` for any of them.
- Hold `rdy`=0 for 3 cycles with a ready entry present:
  - → no dispatch and outputs unchanged; dispatch occurs the cycle after `rdy` returns high.
